// File: rtl/key_input_ctrl.sv
// Push-button conditioner: 2-flop sync, per-key debounce FSM, sticky W1C pending flags, status word.
// Optional auto-repeat while a key is held is compiled in with `define KEY_REPEAT_EN.
module key_input_ctrl #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int ACTIVE_LOW_KEYS = 1,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] btn,
    input  logic                ack,
    input  logic [31:0]         ack_data,
    output logic [31:0]         key,
    output logic [NUM_KEYS-1:0] press_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_e;

    localparam logic [NUM_KEYS-1:0] RELEASED = {NUM_KEYS{ACTIVE_LOW_KEYS != 0}};
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] fire;
    logic [NUM_KEYS-1:0] level_d;
    logic [NUM_KEYS-1:0] pending_q, pending_d, clr;
    logic [31:0]         key_d;
    logic                unused_ack_bits;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    // Sync flops reset to the released level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ RELEASED;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_state_e       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             fire_k;
        logic             p;

        assign p = pressed[i];

`ifdef KEY_REPEAT_EN
        localparam int             REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
        localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
        logic [REP_W-1:0] rep_q, rep_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rep_q <= '0;
            else        rep_q <= rep_d;
        end
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            fire_k  = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_d   = rep_q;
`endif
            case (state_q)
                IDLE: begin
                    if (p) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        fire_k  = 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = '0;
                    end
`ifdef KEY_REPEAT_EN
                    // Repeat count is held across release bounce; only a fresh press restarts it.
                    else if (rep_q == REP_LAST) begin
                        fire_k = 1'b1;
                        rep_d  = '0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign fire[i]    = fire_k;
        assign level_d[i] = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // A press event on the same edge as its clear leaves the flag set.
    assign clr       = ack ? ack_data[8 +: NUM_KEYS] : '0;
    assign pending_d = (pending_q & ~clr) | fire;

    always_comb begin
        key_d                  = '0;
        key_d[0]               = |pending_d;
        key_d[8 +: NUM_KEYS]   = pending_d;
        key_d[16 +: NUM_KEYS]  = level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            press_pulse <= '0;
            key         <= '0;
        end else begin
            pending_q   <= pending_d;
            press_pulse <= fire;
            key         <= key_d;
        end
    end

    assign unused_ack_bits = ^{ack_data[31:8+NUM_KEYS], ack_data[7:0]};

endmodule

// File: tb/tb_key_input_ctrl.sv
// Scoreboard bench for key_input_ctrl at DEBOUNCE_CYCLES=4, four active-low keys (default build).
module tb_key_input_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn;
    logic        ack;
    logic [31:0] ack_data;
    logic [31:0] key;
    logic [3:0]  press_pulse;

    typedef struct {
        logic [3:0]  pulse;
        logic [31:0] key;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    key_input_ctrl #(
        .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .CNT_W(3), .ACTIVE_LOW_KEYS(1), .REPEAT_CYCLES(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .ack(ack), .ack_data(ack_data),
        .key(key), .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] pulse, input logic [31:0] k);
        exp_t e;
        e.pulse = pulse;
        e.key   = k;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with a pulse must match the oldest expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && press_pulse !== 4'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {28'b0, press_pulse}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse", {28'b0, press_pulse}, {28'b0, e.pulse});
                    check("pulse_key", key, e.key);
                end
            end
        end
    end

    task automatic wait_pulse(input int k, input int exp_edges);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (press_pulse[k] !== 1'b1 && n < 20);
        check($sformatf("latency_key%0d", k), n, exp_edges);
    endtask

    initial begin
        rst_n = 1'b0; btn = 4'hF; ack = 1'b0; ack_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_key", key, 32'h0);
        check("reset_pulse", {28'b0, press_pulse}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_reset_key", key, 32'h0);

        // Clean press of key 0: event on the 7th edge after the first sample.
        @(posedge clk); #1 btn[0] = 1'b0;
        push(4'b0001, 32'h0001_0101);
        wait_pulse(0, 7);
        @(negedge clk);
        check("pulse_one_cycle", {28'b0, press_pulse}, 32'h0);
        check("key0_held", key, 32'h0001_0101);

        // Key 1 bounces: 3 low cycles never reach the 4-cycle debounce.
        for (int r = 0; r < 5; r++) begin
            @(posedge clk); #1 btn[1] = 1'b0;
            repeat (3) @(posedge clk);
            #1 btn[1] = 1'b1;
            repeat (2) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bounce_rejected", key, 32'h0001_0101);

        @(posedge clk); #1 btn[1] = 1'b0;
        push(4'b0010, 32'h0003_0301);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("key1_pressed", key, 32'h0003_0301);

        // W1C clears, one key at a time.
        @(posedge clk); #1 ack = 1'b1; ack_data = 32'h0000_0100;
        @(posedge clk); #1 ack = 1'b0; ack_data = '0;
        @(negedge clk);
        check("clear_key0", key, 32'h0003_0201);
        @(posedge clk); #1 ack = 1'b1; ack_data = 32'h0000_0200;
        @(posedge clk); #1 ack = 1'b0; ack_data = '0;
        @(negedge clk);
        check("clear_key1", key, 32'h0003_0000);

        @(posedge clk); #1 btn = 4'hF;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("released", key, 32'h0);

        // Clear of key 2 lands on the same edge as its press event: set wins.
        @(posedge clk); #1 btn[2] = 1'b0;
        push(4'b0100, 32'h0004_0401);
        repeat (6) @(posedge clk);
        #1 ack = 1'b1; ack_data = 32'h0000_0400;
        @(posedge clk); #1 ack = 1'b0; ack_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("collision_set_wins", key, 32'h0004_0401);

        @(posedge clk); #1 ack = 1'b1; ack_data = 32'h0;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
        check("ack_zero_no_effect", key, 32'h0004_0401);

        // Async reset while key 3 is in PRESS_WAIT with cnt=2.
        @(posedge clk); #1 btn[3] = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_key", key, 32'h0);
        btn = 4'hF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("no_event_after_reset", key, 32'h0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
